// File: rtl/dff_test_pkg.sv
// Shared types and constants for the flip-flop chain test sequencer.
//   DFF_CHAIN_LEN : default chain length / pattern width
//   dff_state_e   : sequencer states
package dff_test_pkg;

  localparam int unsigned DFF_CHAIN_LEN = 8;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StSettle,
    StShiftOut,
    StDone
  } dff_state_e;

endpackage

// File: rtl/dff_chain_ctrl_if.sv
// Bundle of the sequencer's test-logic and chain-side signals.
//   start, abort, pattern : test request from top-level logic
//   chain_q               : serial output of the last chain flip-flop
//   chain_d, chain_en     : serial data and clock enable into the chain
//   busy, done, pass      : sequencer status
//   q_capture             : bits read back from the chain
// Modport master is the environment (test logic plus chain); slave is the sequencer.
interface dff_chain_ctrl_if
  import dff_test_pkg::*;
#(
  parameter int unsigned N = DFF_CHAIN_LEN
) ();

  logic         start;
  logic         abort;
  logic [N-1:0] pattern;
  logic         chain_q;
  logic         chain_d;
  logic         chain_en;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N-1:0] q_capture;

  modport master (
    output start, abort, pattern, chain_q,
    input  chain_d, chain_en, busy, done, pass, q_capture
  );

  modport slave (
    input  start, abort, pattern, chain_q,
    output chain_d, chain_en, busy, done, pass, q_capture
  );

endinterface

// File: rtl/dff_chain_capture.sv
// N-bit right-shift capture register. Serial data enters at the MSB, so after N
// shifts bit k holds the k-th bit received.
//   clk, rst_n    : clock, async active-low reset
//   clr_i         : synchronous clear (wins over shift)
//   shift_i       : shift one bit in
//   din_i         : serial input
//   q_o           : register contents
//   shift_val_o   : value the register would take on a shift (lets the
//                   controller compare against the final contents early)
module dff_chain_capture #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         din_i,
  output logic [N-1:0] q_o,
  output logic [N-1:0] shift_val_o
);

  logic [N-1:0] cap_q, cap_d;
  logic [N-1:0] shifted;

  // Written as a loop so that N=1 needs no special case.
  always_comb begin
    shifted        = '0;
    shifted[N-1]   = din_i;
    for (int i = 0; i < int'(N) - 1; i++) begin
      shifted[i] = cap_q[i+1];
    end
  end

  always_comb begin
    cap_d = cap_q;
    if (clr_i) begin
      cap_d = '0;
    end else if (shift_i) begin
      cap_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign q_o         = cap_q;
  assign shift_val_o = shifted;

endmodule

// File: rtl/dff_chain_ctrl.sv
// Test sequencer for a serial chain of master-slave D flip-flops. Latches a
// pattern, shifts it in LSB first, idles one settle cycle, shifts the chain back
// out while flushing zeros, and compares the captured bits with the pattern.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of dff_chain_ctrl_if (request, chain and status)
// chain_d, chain_en and busy are decoded from state/counter; done and pass are
// registered.
module dff_chain_ctrl
  import dff_test_pkg::*;
#(
  parameter int unsigned N = DFF_CHAIN_LEN
) (
  input logic            clk,
  input logic            rst_n,
  dff_chain_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N - 1);

  dff_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     pat_q, pat_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             cap_clr;
  logic             cap_shift;
  logic [N-1:0]     cap_val;
  logic [N-1:0]     cap_shift_val;
  logic [N-1:0]     pat_sel;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    cap_clr   = 1'b0;
    cap_shift = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          pat_d   = bus.pattern;
          cap_clr = 1'b1;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = StShiftIn;
        end
      end
      StShiftIn: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StSettle: begin
        state_d = StShiftOut;
      end
      StShiftOut: begin
        cap_shift = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StDone;
          done_d  = 1'b1;
          // Compare against the post-shift value so pass is valid with done.
          pass_d  = (cap_shift_val == pat_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Abort freezes the partial capture and drops back to idle without done.
    if (bus.abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      cnt_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      cap_shift = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  dff_chain_capture #(
    .N(N)
  ) u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (cap_clr),
    .shift_i     (cap_shift),
    .din_i       (bus.chain_q),
    .q_o         (cap_val),
    .shift_val_o (cap_shift_val)
  );

  // Shift instead of a variable bit-select: the counter is wider than the index.
  assign pat_sel = pat_q >> cnt_q;

  assign bus.chain_en  = (state_q == StShiftIn) || (state_q == StShiftOut);
  assign bus.chain_d   = (state_q == StShiftIn) ? pat_sel[0] : 1'b0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.q_capture = cap_val;

endmodule

// File: tb/tb_dff_chain_ctrl.sv
module tb_dff_chain_ctrl;
  import dff_test_pkg::*;

  localparam int unsigned N = DFF_CHAIN_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dff_chain_ctrl_if #(.N(N)) bus ();

  dff_chain_ctrl #(
    .N(N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural chain: data enters stage 0, chain_q is the last stage.
  logic [N-1:0] chain = '0;
  logic         stuck0 = 1'b0;
  always @(posedge clk) begin
    if (bus.chain_en) chain <= {chain[N-2:0], bus.chain_d};
  end
  assign bus.chain_q = stuck0 ? 1'b0 : chain[N-1];

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entries: {pass, q_capture}
  logic [N:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        logic [N:0] e;
        e = exp_q.pop_front();
        chk("q_capture", 32'(bus.q_capture), 32'(e[N-1:0]));
        chk("pass", 32'(bus.pass), 32'(e[N]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit en_window(input int c, input int base);
    return ((c >= base + 1) && (c <= base + 8)) || ((c >= base + 10) && (c <= base + 17));
  endfunction

  // One full test; cycle c is the period following edge c-1 (start sampled at edge 0).
  task automatic run_seq(input logic [N-1:0] pat, input bit fault, input int busy_cyc);
    logic [N-1:0] exp_cap;
    stuck0  = fault;
    exp_cap = fault ? '0 : pat;
    exp_q.push_back({(exp_cap == pat), exp_cap});
    bus.pattern = pat;
    bus.start   = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
      chk("busy", 32'(bus.busy), 32'(c <= 18));
      chk("chain_en", 32'(bus.chain_en), 32'(en_window(c, 0)));
      chk("done", 32'(bus.done), 32'(c == 18));
      if (c <= 8) chk("chain_d", 32'(bus.chain_d), 32'(pat[c-1]));
      if (c == busy_cyc) begin
        bus.start   = 1'b1;
        bus.pattern = '1;
      end
      if (c == busy_cyc + 1) bus.start = 1'b0;
    end
    stuck0 = 1'b0;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_chain_en", 32'(bus.chain_en), 32'd0);
    chk("rst_q_capture", 32'(bus.q_capture), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Nominal, stuck-at-0 and start-while-busy.
    run_seq(8'hA5, 1'b0, 0);
    run_seq(8'hFF, 1'b1, 0);
    run_seq(8'h3C, 1'b0, 5);
    chk("pass_held", 32'(bus.pass), 32'd1);

    // Abort during readout.
    bus.pattern = 8'hC3;
    bus.start   = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
      if (c == 12) chk("abort_pre_en", 32'(bus.chain_en), 32'd1);
      if (c == 12) bus.abort = 1'b1;
      if (c >= 13) begin
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_en", 32'(bus.chain_en), 32'd0);
        chk("abort_pass", 32'(bus.pass), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        bus.abort = 1'b0;
      end
    end

    // Async reset in the middle of shift-in.
    bus.pattern = 8'h77;
    bus.start   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
    end
    chk("pre_rst_en", 32'(bus.chain_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_en", 32'(bus.chain_en), 32'd0);
    chk("mid_rst_d", 32'(bus.chain_d), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_pass", 32'(bus.pass), 32'd0);
    chk("mid_rst_q", 32'(bus.q_capture), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_seq(8'h5A, 1'b0, 0);

    // Back-to-back with start held high.
    exp_q.push_back({1'b1, 8'h81});
    exp_q.push_back({1'b1, 8'h81});
    bus.pattern = 8'h81;
    bus.start   = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      step();
      chk("b2b_done", 32'(bus.done), 32'((c == 18) || (c == 37)));
      chk("b2b_busy", 32'(bus.busy), 32'(!((c == 19) || (c == 38))));
      chk("b2b_en", 32'(bus.chain_en), 32'(en_window(c, 0) || en_window(c, 19)));
    end
    bus.start = 1'b0;
    step();
    step();
    chk("idle_after_b2b", 32'(bus.busy), 32'd0);
    chk("pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
